// File: rtl/lbm_bram_stream_reader.sv
// lbm_bram_stream_reader
// Streams one frame of DEPTH lattice cells from the direction BRAM banks onto
// an AXI4-Stream master, one beat per cell. Reads are issued against a credit
// budget equal to the prefetch FIFO depth, so the FIFO can never overflow no
// matter how long the downstream stalls. Read issue pauses while the solver
// owns the BRAMs (chunk_transfer_ready), and a one-cycle frame_done pulse
// follows acceptance of the tlast beat.
module lbm_bram_stream_reader #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_DIRS     = 9,
  parameter int DEPTH        = 2500,
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic                             m00_axis_aclk,
  input  logic                             m00_axis_aresetn,
  input  logic                             frame_ready,
  input  logic                             chunk_transfer_ready,
  output logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic                             rd_en,
  input  logic [NUM_DIRS*DATA_WIDTH-1:0]   rd_data,
  input  logic                             m00_axis_tready,
  output logic                             m00_axis_tvalid,
  output logic [NUM_DIRS*DATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [NUM_DIRS*DATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                             m00_axis_tlast,
  output logic                             busy,
  output logic                             frame_done
);

  localparam int STREAM_W   = NUM_DIRS * DATA_WIDTH;
  // One slot per read that can be in flight plus two so that a full-rate
  // stream keeps flowing while the BRAM pipeline refills.
  localparam int FIFO_DEPTH = READ_LATENCY + 2;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  // Wide enough for in-flight reads plus FIFO occupancy.
  localparam int OCC_W      = $clog2(FIFO_DEPTH + READ_LATENCY + 1);
  // Issue and beat counters carry one spare bit so DEPTH itself is
  // representable and nothing wraps within a frame.
  localparam int CNT_W      = ADDR_WIDTH + 1;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] CREDITS  = OCC_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]      issue_addr;
  logic [CNT_W-1:0]      beat_cnt;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic [READ_LATENCY-1:0] rd_valid_sr;
  logic [OCC_W-1:0]      inflight;
  logic [OCC_W-1:0]      fifo_count;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [STREAM_W-1:0]   fifo_mem [FIFO_DEPTH];

  logic start;
  logic issue;
  logic push;
  logic pop;
  logic last_pop;

  // Count reads currently travelling through the BRAM pipeline.
  always_comb begin
    // NOTE: every variable written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + OCC_W'(rd_valid_sr[i]);
    end
  end

  // A frame starts only from IDLE and only while the solver is not writing.
  assign start = (state == IDLE) && frame_ready && !chunk_transfer_ready;

  // A read may go out only while a FIFO slot is guaranteed for its data.
  assign issue = (state == STREAM) && !chunk_transfer_ready &&
                 ((inflight + fifo_count) < CREDITS) &&
                 (issue_addr <= LAST_IDX);

  assign push     = rd_valid_sr[READ_LATENCY-1];
  assign pop      = m00_axis_tvalid && m00_axis_tready;
  assign last_pop = pop && m00_axis_tlast;

  // State register.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: leave STREAM once the final address is issued, leave
  // DRAIN once the tlast beat is taken.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = STREAM;
      STREAM:  if (issue && (issue_addr == LAST_IDX)) state_next = DRAIN;
      DRAIN:   if (last_pop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Issue address: restarts at zero per frame, advances per issued read.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      issue_addr <= '0;
    end else if (start) begin
      issue_addr <= '0;
    end else if (issue) begin
      issue_addr <= issue_addr + 1'b1;
    end
  end

  // Remember the last issued address so rd_addr holds while rd_en is low.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      addr_hold <= '0;
    end else if (issue) begin
      addr_hold <= issue_addr[ADDR_WIDTH-1:0];
    end
  end

  assign rd_en   = issue;
  assign rd_addr = issue ? issue_addr[ADDR_WIDTH-1:0] : addr_hold;

  // Valid shift register: the tap at READ_LATENCY-1 marks the cycle in
  // which rd_data carries the word for an earlier rd_en.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      rd_valid_sr <= '0;
    end else begin
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        rd_valid_sr[i] <= rd_valid_sr[i-1];
      end
      rd_valid_sr[0] <= issue;
    end
  end

  // FIFO storage: captures returning BRAM words.
  always_ff @(posedge m00_axis_aclk) begin
    // NOTE: the data array carries no reset; occupancy and pointers are reset,
    // so stale contents are never presented as valid.
    if (push) begin
      fifo_mem[wr_ptr] <= rd_data;
    end
  end

  // FIFO pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      fifo_count <= fifo_count + OCC_W'(push) - OCC_W'(pop);
    end
  end

  // Beat counter: index of the cell currently at the head of the stream.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      beat_cnt <= '0;
    end else if (start) begin
      beat_cnt <= '0;
    end else if (pop) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // Frame-complete pulse in the cycle after the tlast beat is accepted.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == DRAIN) && last_pop;
    end
  end

  // The head of the FIFO only moves on a pop, so tdata/tlast stay stable
  // through a stall.
  assign m00_axis_tvalid = (fifo_count != '0);
  assign m00_axis_tdata  = fifo_mem[rd_ptr];
  assign m00_axis_tstrb  = '1;
  assign m00_axis_tlast  = m00_axis_tvalid && (beat_cnt == LAST_IDX);
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_lbm_bram_stream_reader.sv
// Testbench for lbm_bram_stream_reader.
// Two instances run side by side on shared stimulus: one with a 1-cycle and
// one with a 2-cycle BRAM. A behavioural model per instance tracks the frame
// as "which cell was issued when, and which cell is next on the stream" and
// checks every cycle.
module tb_lbm_bram_stream_reader;

  localparam int DW    = 16;
  localparam int ND    = 9;
  localparam int DEPTH = 8;
  localparam int AW    = 4;
  localparam int SW    = ND * DW;

  typedef logic [SW-1:0] word_t;

  typedef struct {
    string      name;
    logic [3:0] ready_pat;   // tready for cycle i is ready_pat[i % 4]
    int         chunk_at;    // raise chunk_transfer_ready after this many beats (-1: never)
    int         chunk_len;   // cycles to hold it high
    bit         repulse;     // pulse frame_ready again mid-frame
    bit         addr_data;   // BRAM word = address replicated, else random
    int         exp_beats;
    int         exp_done;
  } vec_t;

  logic clk         = 1'b0;
  logic rst_n       = 1'b0;
  logic frame_ready = 1'b0;
  logic chunk       = 1'b0;
  logic tready      = 1'b1;

  logic [AW-1:0]   rd_addr [2];
  logic            rd_en   [2];
  word_t           rd_data [2];
  logic            tvalid  [2];
  word_t           tdata   [2];
  logic [SW/8-1:0] tstrb   [2];
  logic            tlast   [2];
  logic            busy    [2];
  logic            done    [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  lbm_bram_stream_reader #(
    .DATA_WIDTH(DW), .NUM_DIRS(ND), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(1)
  ) dut_l1 (
    .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n),
    .frame_ready(frame_ready), .chunk_transfer_ready(chunk),
    .rd_addr(rd_addr[0]), .rd_en(rd_en[0]), .rd_data(rd_data[0]),
    .m00_axis_tready(tready), .m00_axis_tvalid(tvalid[0]),
    .m00_axis_tdata(tdata[0]), .m00_axis_tstrb(tstrb[0]),
    .m00_axis_tlast(tlast[0]), .busy(busy[0]), .frame_done(done[0])
  );

  lbm_bram_stream_reader #(
    .DATA_WIDTH(DW), .NUM_DIRS(ND), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(2)
  ) dut_l2 (
    .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n),
    .frame_ready(frame_ready), .chunk_transfer_ready(chunk),
    .rd_addr(rd_addr[1]), .rd_en(rd_en[1]), .rd_data(rd_data[1]),
    .m00_axis_tready(tready), .m00_axis_tvalid(tvalid[1]),
    .m00_axis_tdata(tdata[1]), .m00_axis_tstrb(tstrb[1]),
    .m00_axis_tlast(tlast[1]), .busy(busy[1]), .frame_done(done[1])
  );

  // ---------------- BRAM model ----------------
  word_t bram [DEPTH];
  word_t pipe_l2;

  function automatic word_t garbage();
    word_t w;
    for (int k = 0; k < ND; k++) w[k*DW +: DW] = DW'($urandom);
    return w;
  endfunction

  task automatic load_bram(input bit addr_data);
    for (int a = 0; a < DEPTH; a++) begin
      if (addr_data) begin
        for (int k = 0; k < ND; k++) bram[a][k*DW +: DW] = DW'(a);
      end else begin
        bram[a] = garbage();
      end
    end
  endtask

  // Data returns exactly READ_LATENCY cycles after rd_en; other cycles carry
  // junk so a mistimed capture shows up as bad data.
  always @(posedge clk) begin
    rd_data[0] <= rd_en[0] ? bram[rd_addr[0][2:0]] : garbage();
    pipe_l2    <= rd_en[1] ? bram[rd_addr[1][2:0]] : garbage();
    rd_data[1] <= pipe_l2;
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic string nm(input int d, input string s);
    return $sformatf("L%0d %s", d + 1, s);
  endfunction

  // ---------------- reference model ----------------
  int   cyc = 0;
  bit   act      [2];
  bit   done_due [2];
  int   iss      [2];
  int   beat     [2];
  logic [AW-1:0] last_addr [2];
  int   issue_cyc [2][DEPTH];
  int   iss_total   [2];
  int   beats_total [2];
  int   done_total  [2];
  int   lasts_total [2];

  always @(negedge clk) begin : model
    bit    was_act;
    bit    exp_rd;
    bit    exp_tv;
    int    lat;
    word_t exp_word;
    for (int d = 0; d < 2; d++) begin
      lat = d + 1;
      if (!rst_n) begin
        check(nm(d, "reset tvalid"), SW'(tvalid[d]), '0);
        check(nm(d, "reset tlast"), SW'(tlast[d]), '0);
        check(nm(d, "reset rd_en"), SW'(rd_en[d]), '0);
        check(nm(d, "reset rd_addr"), SW'(rd_addr[d]), '0);
        check(nm(d, "reset busy"), SW'(busy[d]), '0);
        check(nm(d, "reset frame_done"), SW'(done[d]), '0);
        act[d]       = 1'b0;
        done_due[d]  = 1'b0;
        iss[d]       = 0;
        beat[d]      = 0;
        last_addr[d] = '0;
      end else begin
        was_act = act[d];
        // A read goes out whenever a frame is issuing, the solver is idle and
        // fewer than READ_LATENCY+2 cells are issued but not yet accepted.
        exp_rd = act[d] && !chunk && (iss[d] < DEPTH) && ((iss[d] - beat[d]) < lat + 2);
        check(nm(d, "rd_en"), SW'(rd_en[d]), SW'(exp_rd));
        if (rd_en[d]) begin
          check(nm(d, "rd_addr"), SW'(rd_addr[d]), SW'(iss[d]));
          if (iss[d] < DEPTH) issue_cyc[d][iss[d]] = cyc;
          iss[d]++;
          iss_total[d]++;
          last_addr[d] = rd_addr[d];
        end else begin
          check(nm(d, "rd_addr hold"), SW'(rd_addr[d]), SW'(last_addr[d]));
        end
        check(nm(d, "busy"), SW'(busy[d]), SW'(act[d]));
        check(nm(d, "frame_done"), SW'(done[d]), SW'(done_due[d]));
        if (done[d]) done_total[d]++;
        // A cell is on the stream once its read has had lat+1 cycles.
        exp_tv = (beat[d] < iss[d]) && (beat[d] < DEPTH) &&
                 (issue_cyc[d][beat[d] % DEPTH] + lat + 1 <= cyc);
        check(nm(d, "tvalid"), SW'(tvalid[d]), SW'(exp_tv));
        if (tvalid[d]) begin
          exp_word = (beat[d] < DEPTH) ? bram[beat[d] % DEPTH] : '0;
          check(nm(d, "tdata"), tdata[d], exp_word);
          check(nm(d, "tlast"), SW'(tlast[d]), SW'(beat[d] == DEPTH - 1));
          check(nm(d, "tstrb"), SW'(tstrb[d]), SW'({(SW/8){1'b1}}));
        end
        done_due[d] = 1'b0;
        if (tvalid[d] && tready) begin
          beats_total[d]++;
          if (tlast[d]) lasts_total[d]++;
          if (beat[d] == DEPTH - 1) begin
            done_due[d] = 1'b1;
            act[d]      = 1'b0;
          end
          beat[d]++;
        end
        if (!was_act && frame_ready && !chunk) begin
          act[d]  = 1'b1;
          iss[d]  = 0;
          beat[d] = 0;
        end
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vector(input vec_t v);
    int b0, b1, d0, d1, l0, l1, n, chunk_left;
    bit chunk_used;
    load_bram(v.addr_data);
    b0 = beats_total[0]; b1 = beats_total[1];
    d0 = done_total[0];  d1 = done_total[1];
    l0 = lasts_total[0]; l1 = lasts_total[1];
    chunk = 1'b0;
    tready = v.ready_pat[0];
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    n = 1;
    chunk_left = 0;
    chunk_used = 1'b0;
    while ((done_total[0] - d0 < 1 || done_total[1] - d1 < 1) && n < 300) begin
      tready = v.ready_pat[n % 4];
      if (v.repulse) frame_ready = (n == 3);
      if (!chunk_used && v.chunk_at >= 0 && beats_total[0] - b0 >= v.chunk_at) begin
        chunk_used = 1'b1;
        chunk_left = v.chunk_len;
      end
      chunk = (chunk_left > 0);
      if (chunk_left > 0) chunk_left--;
      tick();
      n++;
    end
    frame_ready = 1'b0;
    chunk = 1'b0;
    tready = 1'b1;
    repeat (4) tick();
    check({v.name, " completes in budget"}, SW'(n < 300), SW'(1));
    check({v.name, " L1 beats"}, SW'(beats_total[0] - b0), SW'(v.exp_beats));
    check({v.name, " L2 beats"}, SW'(beats_total[1] - b1), SW'(v.exp_beats));
    check({v.name, " L1 frame_done count"}, SW'(done_total[0] - d0), SW'(v.exp_done));
    check({v.name, " L2 frame_done count"}, SW'(done_total[1] - d1), SW'(v.exp_done));
    check({v.name, " L1 tlast count"}, SW'(lasts_total[0] - l0), SW'(v.exp_done));
    check({v.name, " L2 tlast count"}, SW'(lasts_total[1] - l1), SW'(v.exp_done));
  endtask

  vec_t vecs [8];

  initial begin
    int s0, s1, b0, d0, d1, l0, l1, n;

    vecs[0] = '{"basic",      4'b1111, -1, 0, 1'b0, 1'b1, DEPTH, 1};
    vecs[1] = '{"ready_1001", 4'b1001, -1, 0, 1'b0, 1'b1, DEPTH, 1};
    vecs[2] = '{"chunk_b3",   4'b1111,  3, 5, 1'b0, 1'b1, DEPTH, 1};
    vecs[3] = '{"repulse",    4'b1111, -1, 0, 1'b1, 1'b1, DEPTH, 1};
    for (int i = 4; i < 8; i++) begin
      vecs[i] = '{$sformatf("rand%0d", i), 4'($urandom) | 4'b0001,
                  int'($urandom_range(0, 9)), int'($urandom_range(1, 6)),
                  1'($urandom_range(0, 1)), 1'b0, DEPTH, 1};
    end

    load_bram(1'b1);
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vector(vecs[i]);

    // Long stall after start: reads stop at the credit limit.
    load_bram(1'b1);
    s0 = iss_total[0]; s1 = iss_total[1];
    d0 = done_total[0]; d1 = done_total[1];
    tready = 1'b0;
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    repeat (20) tick();
    check("stall L1 reads issued", SW'(iss_total[0] - s0), SW'(3));
    check("stall L2 reads issued", SW'(iss_total[1] - s1), SW'(4));
    tready = 1'b1;
    n = 0;
    while ((done_total[0] - d0 < 1 || done_total[1] - d1 < 1) && n < 60) begin
      tick();
      n++;
    end
    check("stall L1 frame completes", SW'(done_total[0] - d0), SW'(1));
    check("stall L2 frame completes", SW'(done_total[1] - d1), SW'(1));

    // Solver busy during the request: the request is dropped.
    chunk = 1'b1;
    frame_ready = 1'b1;
    repeat (3) tick();
    check("chunk blocks start L1 busy", SW'(busy[0]), '0);
    check("chunk blocks start L2 busy", SW'(busy[1]), '0);
    chunk = 1'b0;
    frame_ready = 1'b0;
    tick();
    check("no queued start L1 busy", SW'(busy[0]), '0);
    check("no queued start L2 busy", SW'(busy[1]), '0);

    // Reset in the middle of a frame.
    load_bram(1'b1);
    b0 = beats_total[0];
    d0 = done_total[0]; d1 = done_total[1];
    l0 = lasts_total[0]; l1 = lasts_total[1];
    tready = 1'b1;
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    n = 0;
    while (beats_total[0] - b0 < 4 && n < 40) begin
      tick();
      n++;
    end
    check("reset reached beat 4", SW'(beats_total[0] - b0), SW'(4));
    rst_n = 1'b0;
    #1;
    check("async reset L1 tvalid", SW'(tvalid[0]), '0);
    check("async reset L2 tvalid", SW'(tvalid[1]), '0);
    check("async reset L1 busy", SW'(busy[0]), '0);
    check("async reset L2 busy", SW'(busy[1]), '0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check("abandoned L1 no frame_done", SW'(done_total[0] - d0), '0);
    check("abandoned L2 no frame_done", SW'(done_total[1] - d1), '0);
    check("abandoned L1 no tlast", SW'(lasts_total[0] - l0), '0);
    check("abandoned L2 no tlast", SW'(lasts_total[1] - l1), '0);
    run_vector(vecs[0]);

    // Back-to-back: a request in the frame_done cycle starts the next frame.
    load_bram(1'b1);
    d0 = done_total[0]; d1 = done_total[1];
    tready = 1'b1;
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    n = 0;
    while (!done_due[0] && n < 60) begin
      tick();
      n++;
    end
    check("b2b first frame ends", SW'(done_due[0]), SW'(1));
    frame_ready = 1'b1;
    repeat (2) tick();
    frame_ready = 1'b0;
    n = 0;
    while ((done_total[0] - d0 < 2 || done_total[1] - d1 < 2) && n < 80) begin
      tick();
      n++;
    end
    repeat (4) tick();
    check("b2b L1 two frames", SW'(done_total[0] - d0), SW'(2));
    check("b2b L2 two frames", SW'(done_total[1] - d1), SW'(2));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
